// File: rtl/comp_acc_avg_if.sv
// Sample-stream in / frame-result out bundle for comp_acc_avg.
// The master is the upstream source that feeds samples and reads the frame results.
interface comp_acc_avg_if #(
   parameter int DW    = 8,
   parameter int LOG2N = 3
);
   localparam int SW = DW + LOG2N;

   logic          clr;
   logic          din_vld;
   logic [DW-1:0] din;
   logic [SW-1:0] sum;
   logic [DW-1:0] mean;
   logic          dout_vld;
   logic          busy;

   modport master (output clr, din_vld, din, input sum, mean, dout_vld, busy);
   modport slave  (input clr, din_vld, din, output sum, mean, dout_vld, busy);
endinterface

// File: rtl/comp_acc_avg.sv
// Frame accumulator: sums 2^LOG2N two's-complement samples and emits the full-precision sum
// together with the floor mean (arithmetic shift), qualified by a one-cycle done pulse.
module comp_acc_avg #(
   parameter int DW    = 8,
   parameter int LOG2N = 3,
   localparam int SW   = DW + LOG2N
) (
   input logic            clk,
   input logic            rst,
   comp_acc_avg_if.slave  bus
);
   localparam logic [LOG2N-1:0] LAST = '1;

   logic signed [SW-1:0] acc;
   logic        [LOG2N-1:0] cnt;
   logic signed [SW-1:0] sum_q;
   logic        [DW-1:0] mean_q;
   logic                 dout_vld_q;
   logic signed [SW-1:0] din_ext;
   logic signed [SW-1:0] total;

   // 0x80 stays -128; sign extension alone gives the converter's "-0" its intended value.
   assign din_ext = {{LOG2N{bus.din[DW-1]}}, bus.din};
   assign total   = acc + din_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         cnt        <= '0;
         sum_q      <= '0;
         mean_q     <= '0;
         dout_vld_q <= 1'b0;
      end else begin
         dout_vld_q <= 1'b0;
         if (bus.clr) begin
            acc <= '0;
            cnt <= '0;
         end else if (bus.din_vld) begin
            if (cnt == LAST) begin
               sum_q      <= total;
               mean_q     <= total[SW-1:LOG2N];
               dout_vld_q <= 1'b1;
               acc        <= '0;
               cnt        <= '0;
            end else begin
               acc <= total;
               cnt <= cnt + LOG2N'(1);
            end
         end
      end
   end

   assign bus.sum      = sum_q;
   assign bus.mean     = mean_q;
   assign bus.dout_vld = dout_vld_q;
   assign bus.busy     = (cnt != '0);
endmodule

// File: tb/tb_comp_acc_avg.sv
// Scoreboard bench for comp_acc_avg: expected frame results are queued as frames are driven.
module tb_comp_acc_avg;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   comp_acc_avg_if #(.DW(8), .LOG2N(3)) bus ();
   comp_acc_avg #(.DW(8), .LOG2N(3)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;
   logic [10:0] exp_sum[$];
   logic [7:0]  exp_mean[$];
   int cyc = 0;
   int pulses = 0;
   int pulse_cyc[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every done pulse must match the oldest queued frame result.
   always @(negedge clk) begin
      if (!rst && bus.dout_vld === 1'b1) begin
         pulses++;
         pulse_cyc.push_back(cyc);
         if (exp_sum.size() == 0) begin
            chk("unexpected_dout_vld", 32'(bus.dout_vld), 32'd0);
         end else begin
            chk("sum", 32'(bus.sum), 32'(exp_sum.pop_front()));
            chk("mean", 32'(bus.mean), 32'(exp_mean.pop_front()));
         end
      end
   end

   task automatic drive(input logic vld, input logic [7:0] d, input logic c);
      bus.din_vld = vld;
      bus.din     = d;
      bus.clr     = c;
      @(posedge clk);
      #1;
      bus.din_vld = 1'b0;
      bus.clr     = 1'b0;
   endtask

   task automatic push(input logic [10:0] s, input logic [7:0] m);
      exp_sum.push_back(s);
      exp_mean.push_back(m);
   endtask

   task automatic frame8(input logic [7:0] v);
      for (int i = 0; i < 8; i++) drive(1'b1, v, 1'b0);
   endtask

   initial begin
      int p0;
      logic [10:0] prev_sum;
      logic [7:0]  prev_mean;
      bus.din_vld = 1'b0;
      bus.din     = '0;
      bus.clr     = 1'b0;

      // reset state
      #12;
      chk("rst_sum", 32'(bus.sum), 32'd0);
      chk("rst_mean", 32'(bus.mean), 32'd0);
      chk("rst_dout_vld", 32'(bus.dout_vld), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 8'h00, 1'b0);

      // 8 x 0x01 with busy/latency tracking
      push(11'h008, 8'h01);
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 8'h01, 1'b0);
         chk($sformatf("busy_after_%0d", i), 32'(bus.busy), (i < 8) ? 32'd1 : 32'd0);
         chk($sformatf("dvld_after_%0d", i), 32'(bus.dout_vld), (i < 8) ? 32'd0 : 32'd1);
      end
      drive(1'b0, 8'h00, 1'b0);
      chk("dvld_one_cycle", 32'(bus.dout_vld), 32'd0);

      // back-to-back extremes, pulses must be 8 cycles apart
      push(11'h400, 8'h80);
      push(11'h3F8, 8'h7F);
      p0 = pulses;
      frame8(8'h80);
      frame8(8'h7F);
      drive(1'b0, 8'h00, 1'b0);
      chk("b2b_pulses", 32'(pulses - p0), 32'd2);
      if (pulse_cyc.size() >= 2)
         chk("b2b_gap", 32'(pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2]), 32'd8);

      // floor rounding
      push(11'h7FF, 8'hFF);
      drive(1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < 7; i++) drive(1'b1, 8'h00, 1'b0);
      push(11'h007, 8'h00);
      for (int i = 0; i < 7; i++) drive(1'b1, 8'h01, 1'b0);
      drive(1'b1, 8'h00, 1'b0);
      push(11'h7F8, 8'hFF);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'h03, 1'b0);
         drive(1'b1, 8'hFB, 1'b0);
      end
      drive(1'b0, 8'h00, 1'b0);

      // gaps then clr with a coincident sample
      prev_sum  = 11'h7F8;
      prev_mean = 8'hFF;
      p0 = pulses;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'h10, 1'b0);
         for (int g = $urandom_range(0, 3); g > 0; g--) drive(1'b0, 8'h55, 1'b0);
      end
      chk("busy_before_clr", 32'(bus.busy), 32'd1);
      drive(1'b1, 8'h10, 1'b1);
      chk("clr_busy", 32'(bus.busy), 32'd0);
      chk("clr_dout_vld", 32'(bus.dout_vld), 32'd0);
      chk("clr_sum_hold", 32'(bus.sum), 32'(prev_sum));
      chk("clr_mean_hold", 32'(bus.mean), 32'(prev_mean));
      push(11'h010, 8'h02);
      frame8(8'h02);
      drive(1'b0, 8'h00, 1'b0);
      chk("clr_then_frame_pulses", 32'(pulses - p0), 32'd1);

      // clr coinciding with what would be the final sample
      p0 = pulses;
      for (int i = 0; i < 7; i++) drive(1'b1, 8'h11, 1'b0);
      drive(1'b1, 8'h11, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
      chk("clr_final_no_pulse", 32'(pulses - p0), 32'd0);

      // async reset mid-frame
      for (int i = 0; i < 4; i++) drive(1'b1, 8'h05, 1'b0);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_sum", 32'(bus.sum), 32'd0);
      chk("async_rst_mean", 32'(bus.mean), 32'd0);
      chk("async_rst_busy", 32'(bus.busy), 32'd0);
      chk("async_rst_dvld", 32'(bus.dout_vld), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      p0 = pulses;
      push(11'h008, 8'h01);
      frame8(8'h01);
      drive(1'b0, 8'h00, 1'b0);
      chk("post_rst_pulses", 32'(pulses - p0), 32'd1);

      // random frames with random gaps, expectation from integer arithmetic
      for (int f = 0; f < 4; f++) begin
         int s, m;
         logic [7:0] v[8];
         s = 0;
         for (int i = 0; i < 8; i++) begin
            v[i] = 8'($urandom_range(0, 255));
            s += int'($signed(v[i]));
         end
         m = s >>> 3;
         push(s[10:0], m[7:0]);
         for (int i = 0; i < 8; i++) begin
            drive(1'b1, v[i], 1'b0);
            if ($urandom_range(0, 1) == 1) drive(1'b0, 8'hAA, 1'b0);
         end
      end

      repeat (3) drive(1'b0, 8'h00, 1'b0);
      chk("scoreboard_drained", 32'(exp_sum.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/comp_acc_avg.md
Name: comp_acc_avg

Overview:
- Downstream stage of the sign-magnitude to two's-complement converter.
- Consumes its 8-bit two's-complement output as a valid-qualified sample stream and accumulates frames of N = 2^LOG2N samples.
- Per frame, emits a registered full-precision sum and a floor mean (arithmetic shift), with a one-cycle done pulse.
- Feeds later averaging/display logic.

Parameters:
- DW, 8, input sample width (two's complement).
- LOG2N, 3, log2 of samples per frame (N = 8).
- SW, DW+LOG2N, sum width. Derived; not to be overridden. Guarantees no overflow.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- clr  input  1  synchronous frame abort. Discards the partial accumulation.
- din_vld  input  1  din is a valid sample this cycle.
- din  input  DW  two's-complement sample from the converter.
- sum  output  SW  two's-complement frame sum. Registered; holds until the next frame completes.
- mean  output  DW  sum >>> LOG2N, arithmetic (floor). Registered; holds.
- dout_vld  output  1  one-cycle pulse: sum/mean were updated this cycle.
- busy  output  1  high when a frame is partially accumulated (cnt != 0).

Behaviour:
- Reset (async, rst=1): acc=0, cnt=0, sum=0, mean=0, dout_vld=0, busy=0. Takes effect immediately, independent of clk. Any partial frame is lost.
- Internal state:
  - acc: SW-bit signed accumulator.
  - cnt: LOG2N-bit sample counter, 0..N-1, wraps to 0 after the final sample.
- Sample accept: on a clk edge with din_vld=1 and clr=0.
  - din is sign-extended to SW bits.
  - 0x80 is treated as -128. The converter produces it for sign-magnitude "-0"; it is not remapped.
- Non-final sample (cnt < N-1): acc <= acc + sext(din); cnt <= cnt+1.
- Final sample (cnt == N-1):
  - total = acc + sext(din).
  - sum <= total; mean <= total[SW-1:LOG2N]. This is the arithmetic shift: floor, rounds toward -inf.
  - dout_vld <= 1 for exactly one cycle. acc <= 0; cnt <= 0.
  - Latency: dout_vld and new sum/mean are visible the cycle after the edge that captured the Nth sample.
- Back-to-back frames: a sample may be accepted in the same cycle dout_vld is high. No bubble is required.
- din_vld=0: acc/cnt hold. Gaps of any length are allowed mid-frame.
- dout_vld is 0 in every cycle not immediately following a final-sample accept.
- clr=1:
  - acc <= 0, cnt <= 0. sum/mean are unchanged.
  - clr has priority over din_vld: a coincident sample is discarded.
  - If clr coincides with what would be the final sample, no dout_vld is produced.
- Range: sum spans -128*N .. 127*N, so SW = DW+LOG2N never overflows. Mean always fits in DW bits.
- busy = (cnt != 0), combinational from the cnt register.
- All outputs are registered except busy.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> sum=0, mean=0, dout_vld=0, busy=0 immediately.
- 8 consecutive din=0x01 -> one cycle after the 8th edge: dout_vld=1 for 1 cycle, sum=0x008, mean=0x01. busy high after samples 1..7, low after the 8th.
- 8 samples of 0x80 (converter output for sign-mag 0x80) -> sum=0x400 (-1024), mean=0x80. Follow immediately, with no gap, by 8 samples of 0x7F -> sum=0x3F8 (1016), mean=0x7F. Expect two dout_vld pulses exactly 8 cycles apart.
- Floor rounding:
  - Frame with one 0xFF and seven 0x00 -> sum=0x7FF (-1), mean=0xFF (-1).
  - Frame with seven 0x01 and one 0x00 -> sum=0x007, mean=0x00.
  - Alternating 0x03/0xFB -> sum=0x7F8 (-8), mean=0xFF.
- Gaps and clr:
  - Feed 5 samples of 0x10 with random din_vld gaps, then pulse clr together with din_vld=1, din=0x10 -> no dout_vld, busy=0; sum/mean keep their previous values.
  - Then 8 samples of 0x02 -> sum=0x010, mean=0x02.
- Reset mid-frame: 4 samples of 0x05, then assert rst for 1 cycle, then 8 samples of 0x01 -> sum=0x008 (no residue from the aborted frame), exactly one dout_vld pulse.
